sysbus_arbiter: RTL and testbench

//  Shares the single Sysbus master port between two requesters: port 0 = instruction fetch, port 1 = data (load/store).

---
 rtl/sysbus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sysbus_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter
// Shares the single Sysbus master port between two requesters:
//   port 0 = instruction fetch, port 1 = data (load/store).
// Only one transaction is in flight at a time. Requests are arbitrated
// round-robin in IDLE only, request/write beats are forwarded from the
// owner, and read-response beats are routed back to the owner.
//
// Ports
//   clk_i, reset_i                 Sysbus clock, asynchronous active-high reset
//   mN_reqcyc_i / mN_req_i /       requester N request: valid, address or write
//   mN_reqtag_i / mN_reqack_o      beat, tag (bit TAG_W-1: 1 READ / 0 WRITE), accept
//   mN_respcyc_o / mN_resp_o /     read-response beat routed to requester N
//   mN_resptag_o / mN_respack_i    and its acceptance
//   bus_req*_o / bus_reqack_i      Sysbus request channel
//   bus_resp*_i / bus_respack_o    Sysbus response channel
module sysbus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int TAG_W  = 13,
    parameter int BEATS  = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              m0_reqcyc_i,
    input  logic [ADDR_W-1:0] m0_req_i,
    input  logic [TAG_W-1:0]  m0_reqtag_i,
    output logic              m0_reqack_o,
    output logic              m0_respcyc_o,
    output logic [ADDR_W-1:0] m0_resp_o,
    output logic [TAG_W-1:0]  m0_resptag_o,
    input  logic              m0_respack_i,
    input  logic              m1_reqcyc_i,
    input  logic [ADDR_W-1:0] m1_req_i,
    input  logic [TAG_W-1:0]  m1_reqtag_i,
    output logic              m1_reqack_o,
    output logic              m1_respcyc_o,
    output logic [ADDR_W-1:0] m1_resp_o,
    output logic [TAG_W-1:0]  m1_resptag_o,
    input  logic              m1_respack_i,
    output logic              bus_reqcyc_o,
    output logic [ADDR_W-1:0] bus_req_o,
    output logic [TAG_W-1:0]  bus_reqtag_o,
    input  logic              bus_reqack_i,
    input  logic              bus_respcyc_i,
    input  logic [ADDR_W-1:0] bus_resp_i,
    input  logic [TAG_W-1:0]  bus_resptag_i,
    output logic              bus_respack_o
);

    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RWAIT, RDATA} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              lastGrant_q, lastGrant_d;
    logic              isRead_q, isRead_d;
    logic [CNT_W-1:0]  beatCnt_q, beatCnt_d;

    logic              grant;
    logic              ownReqcyc;
    logic [ADDR_W-1:0] ownReq;
    logic [TAG_W-1:0]  ownReqtag;
    logic              ownRespack;
    logic              ownReqack;
    logic              ownRespcyc;
    logic              routeResp;
    logic              writeAccept;
    logic              respAccept;

    // Single requester wins outright; a tie goes to the port that was not granted last.
    assign grant = (m0_reqcyc_i && m1_reqcyc_i) ? ~lastGrant_q : m1_reqcyc_i;

    assign ownReqcyc  = owner_q ? m1_reqcyc_i  : m0_reqcyc_i;
    assign ownReq     = owner_q ? m1_req_i     : m0_req_i;
    assign ownReqtag  = owner_q ? m1_reqtag_i  : m0_reqtag_i;
    assign ownRespack = owner_q ? m1_respack_i : m0_respack_i;

    // A beat only counts when the owner actually presents it, so a stall never loses data.
    assign writeAccept = ownReqcyc && bus_reqack_i;
    assign respAccept  = bus_respcyc_i && bus_respack_o;

    // Next-state and output decode. All outputs derive from state_q, so the async
    // reset forces them to 0 in the same cycle it is asserted.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        lastGrant_d   = lastGrant_q;
        isRead_d      = isRead_q;
        beatCnt_d     = beatCnt_q;
        bus_reqcyc_o  = 1'b0;
        bus_req_o     = '0;
        bus_reqtag_o  = '0;
        bus_respack_o = 1'b0;
        ownReqack     = 1'b0;
        ownRespcyc    = 1'b0;
        routeResp     = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_reqcyc_i || m1_reqcyc_i) begin
                    owner_d     = grant;
                    lastGrant_d = grant;
                    isRead_d    = grant ? m1_reqtag_i[TAG_W-1] : m0_reqtag_i[TAG_W-1];
                    state_d     = ADDR;
                end
            end

            ADDR, WDATA: begin
                bus_reqcyc_o = ownReqcyc;
                bus_req_o    = ownReq;
                bus_reqtag_o = ownReqtag;
                ownReqack    = bus_reqack_i;
                if (writeAccept) begin
                    if (state_q == ADDR) begin
                        beatCnt_d = '0;
                        state_d   = isRead_q ? RWAIT : WDATA;
                    end else if (beatCnt_q == LAST_BEAT) begin
                        beatCnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        beatCnt_d = beatCnt_q + 1'b1;
                    end
                end
            end

            // RWAIT and RDATA route identically; RWAIT only marks that no beat has arrived yet.
            RWAIT, RDATA: begin
                routeResp     = 1'b1;
                ownRespcyc    = bus_respcyc_i;
                bus_respack_o = ownRespack && bus_respcyc_i;
                if ((state_q == RWAIT) && bus_respcyc_i) begin
                    state_d = RDATA;
                end
                if (respAccept) begin
                    if (beatCnt_q == LAST_BEAT) begin
                        beatCnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        beatCnt_d = beatCnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset makes port 0 win the first tie.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            lastGrant_q <= 1'b1;
            isRead_q    <= 1'b0;
            beatCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
            isRead_q    <= isRead_d;
            beatCnt_q   <= beatCnt_d;
        end
    end

    // Per-port fan-out: the non-owner always sees zeros.
    assign m0_reqack_o  = ownReqack  && !owner_q;
    assign m1_reqack_o  = ownReqack  &&  owner_q;
    assign m0_respcyc_o = ownRespcyc && !owner_q;
    assign m1_respcyc_o = ownRespcyc &&  owner_q;
    assign m0_resp_o    = (routeResp && !owner_q) ? bus_resp_i    : '0;
    assign m1_resp_o    = (routeResp &&  owner_q) ? bus_resp_i    : '0;
    assign m0_resptag_o = (routeResp && !owner_q) ? bus_resptag_i : '0;
    assign m1_resptag_o = (routeResp &&  owner_q) ? bus_resptag_i : '0;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter
// Directed bench for sysbus_arbiter: reads, writes with owner stalls,
// round-robin alternation, response back-pressure, stray responses and
// reset in the middle of a read burst.
module tb_sysbus_arbiter;

    localparam int ADDR_W = 64;
    localparam int TAG_W  = 13;
    localparam int BEATS  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        mReqcyc;
    logic [1:0]        mReqack;
    logic [1:0]        mRespcyc;
    logic [1:0]        mRespack;
    logic [ADDR_W-1:0] mReq [2];
    logic [ADDR_W-1:0] mResp [2];
    logic [TAG_W-1:0]  mReqtag [2];
    logic [TAG_W-1:0]  mResptag [2];
    logic              busReqcyc;
    logic [ADDR_W-1:0] busReq;
    logic [TAG_W-1:0]  busReqtag;
    logic              busReqack;
    logic              busRespcyc;
    logic [ADDR_W-1:0] busResp;
    logic [TAG_W-1:0]  busResptag;
    logic              busRespack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sysbus_arbiter #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .BEATS(BEATS)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .m0_reqcyc_i   (mReqcyc[0]),
        .m0_req_i      (mReq[0]),
        .m0_reqtag_i   (mReqtag[0]),
        .m0_reqack_o   (mReqack[0]),
        .m0_respcyc_o  (mRespcyc[0]),
        .m0_resp_o     (mResp[0]),
        .m0_resptag_o  (mResptag[0]),
        .m0_respack_i  (mRespack[0]),
        .m1_reqcyc_i   (mReqcyc[1]),
        .m1_req_i      (mReq[1]),
        .m1_reqtag_i   (mReqtag[1]),
        .m1_reqack_o   (mReqack[1]),
        .m1_respcyc_o  (mRespcyc[1]),
        .m1_resp_o     (mResp[1]),
        .m1_resptag_o  (mResptag[1]),
        .m1_respack_i  (mRespack[1]),
        .bus_reqcyc_o  (busReqcyc),
        .bus_req_o     (busReq),
        .bus_reqtag_o  (busReqtag),
        .bus_reqack_i  (busReqack),
        .bus_respcyc_i (busRespcyc),
        .bus_resp_i    (busResp),
        .bus_resptag_i (busResptag),
        .bus_respack_o (busRespack)
    );

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Return every bench-driven input to its quiet value.
    task automatic applyStimulus();
        mReqcyc    = 2'b00;
        mReq[0]    = '0;
        mReq[1]    = '0;
        mReqtag[0] = '0;
        mReqtag[1] = '0;
        mRespack   = 2'b00;
        busReqack  = 1'b0;
        busRespcyc = 1'b0;
        busResp    = '0;
        busResptag = '0;
    endtask

    // Advance one clock and land 1ns after the edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Serve one read for the expected owner. Caller leaves the arbiter in IDLE
    // with requests already driven; requests are left untouched on return.
    task automatic serveRead(input int port, input logic [63:0] addr,
                             input logic [TAG_W-1:0] tag, input logic [63:0] base);
        busReqack = 1'b0;
        #1;
        checkOutput("idle_no_reqcyc", {63'b0, busReqcyc}, 64'd0);
        tick();
        #1;
        checkOutput("addr_bus_req", busReq, addr);
        checkOutput("addr_bus_reqtag", {51'b0, busReqtag}, {51'b0, tag});
        busReqack = 1'b1;
        #1;
        checkOutput("addr_owner_ack", {63'b0, mReqack[port]}, 64'd1);
        checkOutput("addr_other_ack", {63'b0, mReqack[1-port]}, 64'd0);
        tick();
        busReqack = 1'b0;
        mRespack  = 2'b11;
        for (int b = 0; b < BEATS; b++) begin
            busRespcyc = 1'b1;
            busResp    = base + 64'(b);
            busResptag = tag;
            #1;
            checkOutput("rd_owner_resp", mResp[port], base + 64'(b));
            checkOutput("rd_other_respcyc", {63'b0, mRespcyc[1-port]}, 64'd0);
            checkOutput("rd_bus_respack", {63'b0, busRespack}, 64'd1);
            if (b == 0) begin
                checkOutput("rd_owner_resptag", {51'b0, mResptag[port]}, {51'b0, tag});
            end
            tick();
        end
        busRespcyc = 1'b0;
        mRespack   = 2'b00;
    endtask

    initial begin
        // Reset with every input active: outputs must all be 0.
        reset      = 1'b1;
        applyStimulus();
        mReqcyc    = 2'b11;
        busReqack  = 1'b1;
        busRespcyc = 1'b1;
        mRespack   = 2'b11;
        #2;
        checkOutput("rst_bus_reqcyc", {63'b0, busReqcyc}, 64'd0);
        checkOutput("rst_reqack", {62'b0, mReqack}, 64'd0);
        checkOutput("rst_respcyc", {62'b0, mRespcyc}, 64'd0);
        checkOutput("rst_bus_respack", {63'b0, busRespack}, 64'd0);
        applyStimulus();
        tick();
        tick();
        reset = 1'b0;

        // Port 0 read with 8 response beats, then a stray response while IDLE.
        $display("[TB] port 0 read");
        mReqcyc[0] = 1'b1;
        mReq[0]    = 64'h1000;
        mReqtag[0] = 13'h1000;
        serveRead(0, 64'h1000, 13'h1000, 64'h0);
        applyStimulus();
        busRespcyc = 1'b1;
        busResp    = 64'h99;
        mRespack   = 2'b11;
        #1;
        checkOutput("stray_bus_respack", {63'b0, busRespack}, 64'd0);
        checkOutput("stray_respcyc", {62'b0, mRespcyc}, 64'd0);
        applyStimulus();

        // Both request continuously after reset: strict 0,1,0,1 alternation.
        $display("[TB] round-robin alternation");
        pulseReset();
        mReqcyc    = 2'b11;
        mReq[0]    = 64'h100;
        mReq[1]    = 64'h200;
        mReqtag[0] = 13'h1001;
        mReqtag[1] = 13'h1002;
        serveRead(0, 64'h100, 13'h1001, 64'h10);
        serveRead(1, 64'h200, 13'h1002, 64'h20);
        serveRead(0, 64'h100, 13'h1001, 64'h30);
        serveRead(1, 64'h200, 13'h1002, 64'h40);
        applyStimulus();

        // Port 1 write of 8 beats with a 2-cycle owner stall after beat 3.
        $display("[TB] port 1 write with stall");
        mReqcyc[1] = 1'b1;
        mReq[1]    = 64'h2000;
        mReqtag[1] = 13'h0055;
        tick();
        #1;
        checkOutput("wr_addr_bus_req", busReq, 64'h2000);
        checkOutput("wr_addr_bus_reqtag", {51'b0, busReqtag}, 64'h0055);
        busReqack = 1'b1;
        tick();
        for (int b = 0; b < BEATS; b++) begin
            mReqcyc[1] = 1'b1;
            mReq[1]    = 64'hA0 + 64'(b);
            #1;
            checkOutput("wr_beat_data", busReq, 64'hA0 + 64'(b));
            checkOutput("wr_beat_reqcyc", {63'b0, busReqcyc}, 64'd1);
            tick();
            if (b == 3) begin
                for (int s = 0; s < 2; s++) begin
                    mReqcyc[1] = 1'b0;
                    #1;
                    checkOutput("wr_stall_reqcyc", {63'b0, busReqcyc}, 64'd0);
                    tick();
                end
            end
        end
        #1;
        checkOutput("wr_done_idle", {63'b0, busReqcyc}, 64'd0);
        applyStimulus();

        // Port 0 read with owner back-pressure for 3 cycles on beat 3.
        $display("[TB] read back-pressure");
        mReqcyc[0] = 1'b1;
        mReq[0]    = 64'h4000;
        mReqtag[0] = 13'h1004;
        tick();
        busReqack = 1'b1;
        tick();
        busReqack  = 1'b0;
        mReqcyc[0] = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            busRespcyc = 1'b1;
            busResp    = 64'h40 + 64'(b);
            busResptag = 13'h1004;
            if (b == 3) begin
                for (int s = 0; s < 3; s++) begin
                    mRespack[0] = 1'b0;
                    #1;
                    checkOutput("bp_bus_respack_low", {63'b0, busRespack}, 64'd0);
                    checkOutput("bp_held_resp", mResp[0], 64'h43);
                    tick();
                end
            end
            mRespack[0] = 1'b1;
            #1;
            checkOutput("bp_bus_respack", {63'b0, busRespack}, 64'd1);
            checkOutput("bp_resp", mResp[0], 64'h40 + 64'(b));
            tick();
        end
        busResp = 64'h48;
        #1;
        checkOutput("bp_done_respack", {63'b0, busRespack}, 64'd0);
        checkOutput("bp_done_respcyc", {63'b0, mRespcyc[0]}, 64'd0);
        applyStimulus();

        // Reset during beat 4 of a port 1 read, then a normal port 0 read.
        $display("[TB] reset mid-burst");
        mReqcyc[1] = 1'b1;
        mReq[1]    = 64'h5000;
        mReqtag[1] = 13'h1ABC;
        tick();
        busReqack = 1'b1;
        tick();
        busReqack  = 1'b0;
        mReqcyc[1] = 1'b0;
        mRespack   = 2'b11;
        for (int b = 0; b < 4; b++) begin
            busRespcyc = 1'b1;
            busResp    = 64'h60 + 64'(b);
            tick();
        end
        busResp = 64'h64;
        #1;
        checkOutput("mid_pre_respcyc", {63'b0, mRespcyc[1]}, 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_respack", {63'b0, busRespack}, 64'd0);
        checkOutput("mid_rst_respcyc", {63'b0, mRespcyc[1]}, 64'd0);
        checkOutput("mid_rst_resp", mResp[1], 64'd0);
        applyStimulus();
        tick();
        reset = 1'b0;
        mReqcyc[0] = 1'b1;
        mReq[0]    = 64'h3000;
        mReqtag[0] = 13'h1003;
        serveRead(0, 64'h3000, 13'h1003, 64'h50);
        applyStimulus();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
